// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: ALU control encodings, ALUOp codes and opcodes
// decoded by the execute/memory slice.
package cpu_pkg;

  localparam int DATA_W = 16;

  // ALUCtrl: [3] invert A, [2] negate B (carry-in 1), [1:0] 00 AND, 01 OR, 10 ADD, 11 SLT
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [3:0] OPC_R0   = 4'b0000;
  localparam logic [3:0] OPC_R1   = 4'b0001;
  localparam logic [3:0] OPC_ADDI = 4'b0100;
  localparam logic [3:0] OPC_SUBI = 4'b0101;
  localparam logic [3:0] OPC_ANDI = 4'b0110;
  localparam logic [3:0] OPC_ORI  = 4'b0111;
  localparam logic [3:0] OPC_SLTI = 4'b1000;

endpackage

// File: rtl/exec_mem_unit_if.sv
// Operand/control bundle between the operand mux/CU and the execute-memory slice,
// plus the results returned towards branch logic and write-back.
interface exec_mem_unit_if;
  logic [1:0]  ALUOp;
  logic [3:0]  Opcode;
  logic [1:0]  Funct;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [15:0] StoreData;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  ALUCtrl;
  logic [15:0] ALUResult;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] MemReadData;

  modport master (
    output ALUOp, Opcode, Funct, OpA, OpB, StoreData, MemRead, MemWrite,
    input  ALUCtrl, ALUResult, Zero, Overflow, CarryOut, MemReadData
  );

  modport slave (
    input  ALUOp, Opcode, Funct, OpA, OpB, StoreData, MemRead, MemWrite,
    output ALUCtrl, ALUResult, Zero, Overflow, CarryOut, MemReadData
  );
endinterface

// File: rtl/exec_mem_dmem.sv
// Byte-addressed data memory holding big-endian 16-bit words; combinational read,
// posedge write, asynchronous clear of every byte while Reset_n is low.
module exec_mem_dmem #(
  parameter int MEM_BYTES = 128
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic [$clog2(MEM_BYTES)-2:0]   word_addr,
  input  logic [15:0]                    wdata,
  input  logic                           we,
  input  logic                           re,
  output logic [15:0]                    rdata
);

  logic [7:0] mem [MEM_BYTES];

  // Reset has priority, so a write requested while Reset_n is low is dropped.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[{word_addr, 1'b0}] <= wdata[15:8];
      mem[{word_addr, 1'b1}] <= wdata[7:0];
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (re) begin
      rdata = {mem[{word_addr, 1'b0}], mem[{word_addr, 1'b1}]};
    end
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the single-cycle CPU: ALU control decode, 16-bit ALU
// and the data memory addressed by the ALU result.
module exec_mem_unit
  import cpu_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic             Clock,
  input  logic             Reset_n,
  exec_mem_unit_if.slave   bus
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [3:0]               alu_ctrl;
  logic signed [DATA_W-1:0] a_op;
  logic signed [DATA_W-1:0] b_op;
  logic [DATA_W:0]          sum;
  logic [DATA_W-1:0]        alu_res;
  logic                     arith;
  logic                     ovf;

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (bus.ALUOp)
      ALUOP_MEM:    alu_ctrl = ALU_ADD;
      ALUOP_BRANCH: alu_ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        if (bus.Opcode == OPC_R0) begin
          unique case (bus.Funct)
            2'b00:   alu_ctrl = ALU_AND;
            2'b01:   alu_ctrl = ALU_OR;
            2'b10:   alu_ctrl = ALU_ADD;
            default: alu_ctrl = ALU_SUB;
          endcase
        end else if (bus.Opcode == OPC_R1) begin
          if (bus.Funct == 2'b00)      alu_ctrl = ALU_SLT;
          else if (bus.Funct == 2'b01) alu_ctrl = ALU_NOR;
          else                         alu_ctrl = ALU_ADD;
        end
      end
      default: begin
        unique case (bus.Opcode)
          OPC_ADDI: alu_ctrl = ALU_ADD;
          OPC_SUBI: alu_ctrl = ALU_SUB;
          OPC_ANDI: alu_ctrl = ALU_AND;
          OPC_ORI:  alu_ctrl = ALU_OR;
          OPC_SLTI: alu_ctrl = ALU_SLT;
          default:  alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  // One adder serves ADD, SUB and SLT; NOR is AND of the inverted operands.
  always_comb begin
    a_op  = alu_ctrl[3] ? ~bus.OpA : bus.OpA;
    b_op  = alu_ctrl[2] ? ~bus.OpB : bus.OpB;
    sum   = {1'b0, a_op} + {1'b0, b_op} + {{DATA_W{1'b0}}, alu_ctrl[2]};
    arith = alu_ctrl[1];
    ovf   = arith && (a_op[DATA_W-1] == b_op[DATA_W-1]) && (sum[DATA_W-1] != a_op[DATA_W-1]);
    unique case (alu_ctrl[1:0])
      2'b00:   alu_res = a_op & b_op;
      2'b01:   alu_res = a_op | b_op;
      2'b10:   alu_res = sum[DATA_W-1:0];
      default: alu_res = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ ovf};
    endcase
  end

  assign bus.ALUCtrl   = alu_ctrl;
  assign bus.ALUResult = alu_res;
  assign bus.Zero      = (alu_res == '0);
  assign bus.Overflow  = ovf;
  assign bus.CarryOut  = arith & sum[DATA_W];

  exec_mem_dmem #(
    .MEM_BYTES (MEM_BYTES)
  ) u_dmem (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .word_addr (alu_res[AW-1:1]),
    .wdata     (bus.StoreData),
    .we        (bus.MemWrite),
    .re        (bus.MemRead),
    .rdata     (bus.MemReadData)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed and randomized checks of exec_mem_unit against an arithmetic reference model.
module tb_exec_mem_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] mem_m [128];

  typedef enum {M_AND, M_OR, M_ADD, M_SUB, M_SLT, M_NOR} op_e;

  always #5 clk = ~clk;

  exec_mem_unit_if bus ();

  exec_mem_unit #(.MEM_BYTES(128)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic op_e ref_op(input logic [1:0] aluop, input logic [3:0] opc, input logic [1:0] fn);
    if (aluop == 2'd0) return M_ADD;
    if (aluop == 2'd1) return M_SUB;
    if (aluop == 2'd2) begin
      if (opc == 4'd0) return (fn == 2'd0) ? M_AND : (fn == 2'd1) ? M_OR : (fn == 2'd2) ? M_ADD : M_SUB;
      if (opc == 4'd1) return (fn == 2'd0) ? M_SLT : (fn == 2'd1) ? M_NOR : M_ADD;
      return M_ADD;
    end
    case (opc)
      4'd4:    return M_ADD;
      4'd5:    return M_SUB;
      4'd6:    return M_AND;
      4'd7:    return M_OR;
      4'd8:    return M_SLT;
      default: return M_ADD;
    endcase
  endfunction

  function automatic void ref_alu(input op_e op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [3:0] ctrl, output logic [15:0] r,
                                  output logic ov, output logic cy);
    int sa, sb, sr, ua, ub;
    sa = int'($signed(a)); sb = int'($signed(b));
    ua = int'(a);          ub = int'(b);
    ov = 1'b0; cy = 1'b0; r = 16'h0; ctrl = 4'h0;
    case (op)
      M_AND: begin ctrl = 4'b0000; r = a & b; end
      M_OR:  begin ctrl = 4'b0001; r = a | b; end
      M_NOR: begin ctrl = 4'b1100; r = ~(a | b); end
      M_ADD: begin
        ctrl = 4'b0010; r = a + b; sr = sa + sb;
        ov = (sr > 32767) || (sr < -32768); cy = (ua + ub) > 65535;
      end
      M_SUB: begin
        ctrl = 4'b0110; r = a - b; sr = sa - sb;
        ov = (sr > 32767) || (sr < -32768); cy = (ua >= ub);
      end
      default: begin
        ctrl = 4'b0111; r = (sa < sb) ? 16'd1 : 16'd0; sr = sa - sb;
        ov = (sr > 32767) || (sr < -32768); cy = (ua >= ub);
      end
    endcase
  endfunction

  task automatic drive(input logic [1:0] aluop, input logic [3:0] opc, input logic [1:0] fn,
                       input logic [15:0] a, input logic [15:0] b);
    bus.ALUOp = aluop; bus.Opcode = opc; bus.Funct = fn; bus.OpA = a; bus.OpB = b;
    #1;
  endtask

  task automatic check_alu(input string tag);
    logic [3:0] c; logic [15:0] r; logic ov, cy;
    ref_alu(ref_op(bus.ALUOp, bus.Opcode, bus.Funct), bus.OpA, bus.OpB, c, r, ov, cy);
    chk({tag, ".ctrl"}, {12'h0, bus.ALUCtrl}, {12'h0, c});
    chk({tag, ".res"},  bus.ALUResult, r);
    chk({tag, ".zero"}, {15'h0, bus.Zero}, {15'h0, r == 16'h0});
    chk({tag, ".ovf"},  {15'h0, bus.Overflow}, {15'h0, ov});
    chk({tag, ".cy"},   {15'h0, bus.CarryOut}, {15'h0, cy});
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] addr);
    int ea;
    ea = int'(addr & 16'h007E);
    return {mem_m[ea], mem_m[ea + 1]};
  endfunction

  task automatic mem_write(input logic [15:0] addr, input logic [15:0] data);
    int ea;
    @(negedge clk);
    drive(2'b00, 4'h0, 2'b00, addr, 16'h0000);
    bus.StoreData = data; bus.MemWrite = 1'b1; bus.MemRead = 1'b0;
    @(posedge clk);
    ea = int'(addr & 16'h007E);
    mem_m[ea] = data[15:8]; mem_m[ea + 1] = data[7:0];
    #1 bus.MemWrite = 1'b0;
  endtask

  initial begin
    logic [15:0] a, b, d;
    logic        w;
    rst_n = 1'b1;
    bus.ALUOp = 2'b00; bus.Opcode = 4'h0; bus.Funct = 2'b00;
    bus.OpA = 16'h0; bus.OpB = 16'h0; bus.StoreData = 16'h0;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;

    @(negedge clk);
    drive(2'b00, 4'h0, 2'b00, 16'h0040, 16'h0000);
    bus.MemRead = 1'b1; #1;
    chk("reset.mem", bus.MemReadData, 16'h0000);
    bus.MemRead = 1'b0; #1;

    drive(2'b10, 4'h0, 2'b10, 16'h7FFF, 16'h0001);
    chk("add_ovf.ctrl", {12'h0, bus.ALUCtrl}, 16'h0002);
    chk("add_ovf.res", bus.ALUResult, 16'h8000);
    chk("add_ovf.ovf", {15'h0, bus.Overflow}, 16'h0001);
    chk("add_ovf.cy", {15'h0, bus.CarryOut}, 16'h0000);
    chk("add_ovf.zero", {15'h0, bus.Zero}, 16'h0000);

    drive(2'b01, 4'h0, 2'b00, 16'h0005, 16'h0005);
    chk("beq.ctrl", {12'h0, bus.ALUCtrl}, 16'h0006);
    chk("beq.res", bus.ALUResult, 16'h0000);
    chk("beq.zero", {15'h0, bus.Zero}, 16'h0001);
    chk("beq.cy", {15'h0, bus.CarryOut}, 16'h0001);
    chk("beq.ovf", {15'h0, bus.Overflow}, 16'h0000);

    drive(2'b10, 4'h1, 2'b00, 16'h8000, 16'h0001);
    chk("slt.res", bus.ALUResult, 16'h0001);
    chk("slt.ovf", {15'h0, bus.Overflow}, 16'h0001);
    drive(2'b10, 4'h1, 2'b00, 16'h0001, 16'h8000);
    chk("slt_swap.res", bus.ALUResult, 16'h0000);

    drive(2'b10, 4'h1, 2'b01, 16'h00F0, 16'h0F00);
    chk("nor.ctrl", {12'h0, bus.ALUCtrl}, 16'h000C);
    chk("nor.res", bus.ALUResult, 16'hF00F);
    drive(2'b11, 4'h6, 2'b00, 16'h00F0, 16'h0F00);
    chk("andi.res", bus.ALUResult, 16'h0000);
    chk("andi.zero", {15'h0, bus.Zero}, 16'h0001);

    mem_write(16'h0014, 16'hBEEF);
    @(negedge clk);
    drive(2'b00, 4'h0, 2'b00, 16'h0010, 16'h0004);
    bus.MemRead = 1'b1; #1;
    chk("ld_beef", bus.MemReadData, 16'hBEEF);
    drive(2'b00, 4'h0, 2'b00, 16'h0015, 16'h0000);
    chk("ld_odd", bus.MemReadData, 16'hBEEF);
    bus.MemRead = 1'b0; #1;
    chk("ld_noread", bus.MemReadData, 16'h0000);

    // Read and write to the same word in one cycle: old value before the edge.
    @(negedge clk);
    drive(2'b00, 4'h0, 2'b00, 16'h0014, 16'h0000);
    bus.MemRead = 1'b1; bus.MemWrite = 1'b1; bus.StoreData = 16'hCAFE; #1;
    chk("rw_before", bus.MemReadData, 16'hBEEF);
    @(posedge clk); mem_m[20] = 8'hCA; mem_m[21] = 8'hFE;
    #1 bus.MemWrite = 1'b0; #1;
    chk("rw_after", bus.MemReadData, 16'hCAFE);
    bus.MemRead = 1'b0;

    mem_write(16'h0020, 16'h1234);
    @(negedge clk);
    drive(2'b00, 4'h0, 2'b00, 16'h0020, 16'h0000);
    bus.MemRead = 1'b1; #1;
    chk("pre_rst", bus.MemReadData, 16'h1234);
    rst_n = 1'b0; #1;
    chk("rst_async", bus.MemReadData, 16'h0000);
    for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
    bus.MemWrite = 1'b1; bus.StoreData = 16'h5A5A;
    @(posedge clk); #2;
    chk("wr_in_rst", bus.MemReadData, 16'h0000);
    rst_n = 1'b1; #1;
    chk("rst_rel", bus.MemReadData, 16'h0000);
    @(posedge clk); mem_m[32] = 8'h5A; mem_m[33] = 8'h5A;
    #1 bus.MemWrite = 1'b0; #1;
    chk("wr_after_rel", bus.MemReadData, 16'h5A5A);
    bus.MemRead = 1'b0;

    for (int i = 0; i < 200; i++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom));
      check_alu("rnd_alu");
    end

    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom_range(0, 3));
      d = 16'($urandom); w = 1'($urandom_range(0, 1));
      drive(2'b00, 4'h0, 2'b00, a, b);
      bus.StoreData = d; bus.MemWrite = w; bus.MemRead = 1'b1; #1;
      chk("rnd_mem", bus.MemReadData, ref_rd(a + b));
      @(posedge clk);
      if (w) begin
        mem_m[int'((a + b) & 16'h007E)]     = d[15:8];
        mem_m[int'((a + b) & 16'h007E) + 1] = d[7:0];
      end
      #1 bus.MemWrite = 1'b0;
    end
    bus.MemRead = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
